bldc_commutator: RTL and testbench
==================================

Name: bldc_commutator

Overview:
- Six-step trapezoidal commutation stage between the hall-sensor inputs, the PWM generator output and the gate-driver pins (INHA/INLA/INHB/INLB/INHC/INLC).
- Synchronises and debounces the three hall lines, decodes the rotor sector, and routes pwm_in to the high side of the active phase and a steady low-side ON to the return phase.
- Inserts dead time on every pattern change, raises a sticky fault on illegal hall codes, and keeps a signed commutation-step position counter for the control loop.

Parameters:
DEADTIME_CYCLES, 16, clk cycles with all gates off between patterns (500 ns at 32 MHz); legal range 1..255.
DEBOUNCE_CYCLES, 32, consecutive stable cycles before a synchronised hall code is accepted; legal range 1..1023.
COUNT_WIDTH, 24, width of the position counter.

Ports:
clk  in  1  32 MHz system clock.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  level; 1 = drive motor.
dir  in  1  0 = forward, 1 = reverse.
pwm_in  in  1  PWM from the pwm block.
hall  in  3  raw hall inputs {h3,h2,h1}, asynchronous.
fault_clr  in  1  single-cycle pulse that clears fault.
gate  out  6  registered {INHA,INLA,INHB,INLB,INHC,INLC}.
sector  out  3  accepted sector 0..5; 7 = unknown.
fault  out  1  sticky invalid-hall fault.
position  out  COUNT_WIDTH  signed commutation-step count.

Behaviour:
- Reset (async assert; release synchronised by the design): gate=0, sector=7, fault=0, position=0, state=IDLE, debounce counter=0, sync flops=0.
- Hall path: 2-FF synchroniser. A candidate code must hold for DEBOUNCE_CYCLES consecutive cycles to be accepted, and any change restarts the count. The accepted code is registered and decoded the next cycle.
- Decode: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. 000 and 111 are invalid.
- Pattern, forward, high/low by sector: 0 A/B, 1 A/C, 2 B/C, 3 B/A, 4 C/A, 5 C/B.
- Pattern, reverse: high and low phases swapped.
- Drive levels: active high-side gate = pwm_in. Active low-side gate = 1. All other gates = 0.
- gate is registered, so pwm_in→gate latency is 1 cycle.
- Invariant: INHx and INLx of the same phase are never 1 in the same cycle, including through any transition.
- FSM states: IDLE, DEADTIME, DRIVE, FAULT.
  - IDLE: gate=0. Moves to DEADTIME when enable=1 and sector is valid.
  - DEADTIME: gate=0 for exactly DEADTIME_CYCLES cycles, then DRIVE using the sector and dir current at exit.
  - DRIVE: gate=pattern. A sector change or dir change moves to DEADTIME and restarts the count; gate=0 from the next cycle.
  - enable=0 in DEADTIME or DRIVE: IDLE, gate=0 on the next cycle.
- Fault:
  - An accepted invalid code in any state sets fault=1, enters FAULT and forces gate=0 on the next cycle; sector holds its last valid value.
  - Fault has priority over enable, dir and sector events.
  - Leaving FAULT requires fault_clr=1 while the accepted code is valid. Fault then returns to 0 and the FSM goes to IDLE, which proceeds per enable.
  - fault_clr with an invalid code present is ignored.
- Position, evaluated on each accepted valid sector change, independent of the FSM:
  - new = (old+1) mod 6 → +1.
  - new = (old−1) mod 6 → −1.
  - Any other jump, or change from unknown (7) → no change.
  - Two's-complement wrap at COUNT_WIDTH.
- Simultaneous events: a sector change in the same cycle as a dir change produces one DEADTIME. enable falling in the same cycle as a sector change goes to IDLE.

Decomposition:
- Shared package bldc_pkg:
  - state enum (IDLE/DEADTIME/DRIVE/FAULT);
  - SECTOR_UNKNOWN=3'd7;
  - hall-to-sector decode function;
  - sector+dir → 6-bit gate-mask function (mask bit set = phase active; high-side bits ANDed with pwm_in);
  - gate bit-index constants.
- One sub-module: hall_debounce (synchroniser + stable-count filter, param DEBOUNCE_CYCLES, outputs accepted code and a one-cycle accept strobe).

Test Plan:
- Reset, enable=1, dir=0, hall=101 held 40 cycles, pwm_in=1 → gate=000000 during debounce plus 16 dead-time cycles, then 100100 (INHA=1, INLB=1); toggling pwm_in toggles only INHA, 1 cycle later.
- Forward rotation 101→100→110→010→011→001→101, each held 500 cycles → sectors 0..5,0; position=+6; exactly 16 zero cycles on each change; no same-phase H/L overlap on any cycle.
- Reverse sequence with dir=1 → position=−6; sector 0 gate = INHB, INLA (011000 with pwm_in=1).
- Glitch hall 101→100 for 10 cycles then back → no sector change, no dead time, position unchanged.
- hall=111 held 40 cycles while driving → fault=1, gate=0; fault_clr with 111 ignored; hall=101 then fault_clr → fault=0, dead time, DRIVE resumes.
- dir toggle mid-DRIVE, then reset_n pulsed low mid-DEADTIME → 16-cycle gap before the swapped pattern; on reset, gate=0 and position=0 asynchronously.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared types, decode tables and gate-pattern helpers for the BLDC six-step commutator.
package bldc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEADTIME,
      ST_DRIVE,
      ST_FAULT
   } state_t;

   localparam logic [2:0] SECTOR_UNKNOWN = 3'd7;

   localparam int G_INHA = 5;
   localparam int G_INLA = 4;
   localparam int G_INHB = 3;
   localparam int G_INLB = 2;
   localparam int G_INHC = 1;
   localparam int G_INLC = 0;

   function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
      case (code)
         3'b101:  return 3'd0;
         3'b100:  return 3'd1;
         3'b110:  return 3'd2;
         3'b010:  return 3'd3;
         3'b011:  return 3'd4;
         3'b001:  return 3'd5;
         default: return SECTOR_UNKNOWN;
      endcase
   endfunction

   // Forward table; reverse swaps the high and low side of every phase.
   function automatic logic [5:0] gate_mask(input logic [2:0] sec, input logic rev);
      logic [5:0] m;
      logic [5:0] r;
      case (sec)
         3'd0:    m = 6'b10_01_00;
         3'd1:    m = 6'b10_00_01;
         3'd2:    m = 6'b00_10_01;
         3'd3:    m = 6'b01_10_00;
         3'd4:    m = 6'b01_00_10;
         3'd5:    m = 6'b00_01_10;
         default: m = 6'b00_00_00;
      endcase
      r = m;
      if (rev) begin
         r[G_INHA] = m[G_INLA];
         r[G_INLA] = m[G_INHA];
         r[G_INHB] = m[G_INLB];
         r[G_INLB] = m[G_INHB];
         r[G_INHC] = m[G_INLC];
         r[G_INLC] = m[G_INHC];
      end
      return r;
   endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser plus stable-count filter for the raw hall lines.
module hall_debounce
   import bldc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] hall,
   output logic [2:0] code,
   output logic       accept
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [2:0]    hall_p0;
   logic [2:0]    hall_p1;
   logic [2:0]    cand;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          seen;
   logic          changed;
   logic          done;
   logic          take;

   // cnt is the number of consecutive cycles the synchronised code has equalled cand.
   always_comb begin
      changed = (hall_p1 != cand);
      cnt_nxt = cnt;
      if (changed)
         cnt_nxt = CW'(1);
      else if (cnt != CNT_MAX)
         cnt_nxt = cnt + CW'(1);
      done = (cnt_nxt == CNT_MAX) && (changed || (cnt != CNT_MAX));
      take = done && (!seen || (hall_p1 != code));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hall_p0 <= 3'd0;
         hall_p1 <= 3'd0;
         cand    <= 3'd0;
         cnt     <= '0;
         code    <= 3'd0;
         seen    <= 1'b0;
         accept  <= 1'b0;
      end else begin
         hall_p0 <= hall;
         hall_p1 <= hall_p0;
         cand    <= hall_p1;
         cnt     <= cnt_nxt;
         accept  <= take;
         if (take) begin
            code <= hall_p1;
            seen <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step trapezoidal commutator: hall decode, dead-time FSM, gate drive,
// sticky invalid-hall fault and signed commutation-step position counter.
module bldc_commutator
   import bldc_pkg::*;
#(
   parameter int DEADTIME_CYCLES = 16,
   parameter int DEBOUNCE_CYCLES = 32,
   parameter int COUNT_WIDTH     = 24
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   dir,
   input  logic                   pwm_in,
   input  logic [2:0]             hall,
   input  logic                   fault_clr,
   output logic [5:0]             gate,
   output logic [2:0]             sector,
   output logic                   fault,
   output logic [COUNT_WIDTH-1:0] position
);

   localparam logic [7:0] DT_LAST = 8'(DEADTIME_CYCLES - 1);

   logic [1:0]                    rst_sync;
   logic                          rst_n_int;
   logic [2:0]                    acc_code;
   logic                          acc_stb;
   logic [2:0]                    dsec;
   logic                          code_valid;
   logic                          bad_ev;
   logic                          sec_chg;
   logic [2:0]                    sector_nxt;
   logic [2:0]                    sec_inc;
   logic [2:0]                    sec_dec;
   logic                          dir_q;
   logic                          dir_chg;
   logic [7:0]                    dt_cnt;
   state_t                        state;
   state_t                        state_nxt;
   logic [5:0]                    gate_d;
   logic signed [COUNT_WIDTH-1:0] pos_q;

   // Reset asserts immediately but is released only on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_int = rst_sync[1];

   hall_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_hall_debounce (
      .clk    (clk),
      .rst_n  (rst_n_int),
      .hall   (hall),
      .code   (acc_code),
      .accept (acc_stb)
   );

   always_comb begin
      dsec       = hall_to_sector(acc_code);
      code_valid = (dsec != SECTOR_UNKNOWN);
      bad_ev     = acc_stb && !code_valid;
      sec_chg    = acc_stb && code_valid && (dsec != sector);
      sector_nxt = sec_chg ? dsec : sector;
      sec_inc    = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
      sec_dec    = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
      dir_chg    = (dir != dir_q);
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state  <= ST_IDLE;
         dt_cnt <= 8'd0;
      end else begin
         state  <= state_nxt;
         dt_cnt <= (state == ST_DEADTIME) ? dt_cnt + 8'd1 : 8'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (enable && (sector != SECTOR_UNKNOWN)) state_nxt = ST_DEADTIME;
         ST_DEADTIME:
            if (!enable)                state_nxt = ST_IDLE;
            else if (dt_cnt == DT_LAST) state_nxt = ST_DRIVE;
         ST_DRIVE:
            if (!enable)                state_nxt = ST_IDLE;
            else if (sec_chg || dir_chg) state_nxt = ST_DEADTIME;
         ST_FAULT:
            if (fault_clr && code_valid) state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
      // An invalid code overrides every other event.
      if (bad_ev) state_nxt = ST_FAULT;
   end

   // Pattern follows the sector/dir that will be current after this edge.
   always_comb begin
      gate_d = 6'b000000;
      if (state_nxt == ST_DRIVE)
         gate_d = gate_mask(sector_nxt, dir) & {pwm_in, 1'b1, pwm_in, 1'b1, pwm_in, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         gate   <= 6'b000000;
         sector <= SECTOR_UNKNOWN;
         fault  <= 1'b0;
         dir_q  <= 1'b0;
         pos_q  <= '0;
      end else begin
         gate   <= gate_d;
         sector <= sector_nxt;
         dir_q  <= dir;
         if (bad_ev)
            fault <= 1'b1;
         else if ((state == ST_FAULT) && (state_nxt == ST_IDLE))
            fault <= 1'b0;
         if (sec_chg && (sector != SECTOR_UNKNOWN)) begin
            if (dsec == sec_inc)
               pos_q <= pos_q + COUNT_WIDTH'(1);
            else if (dsec == sec_dec)
               pos_q <= pos_q - COUNT_WIDTH'(1);
         end
      end
   end

   assign position = pos_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Randomised bench for bldc_commutator against a rule-level reference model.
module tb_bldc_commutator;

   localparam int DT  = 16;
   localparam int DEB = 32;
   localparam int CW  = 24;

   localparam int M_IDLE  = 0;
   localparam int M_DEAD  = 1;
   localparam int M_DRIVE = 2;
   localparam int M_FAULT = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          dir;
   logic          pwm_in;
   logic [2:0]    hall;
   logic          fault_clr;
   logic [5:0]    gate;
   logic [2:0]    sector;
   logic          fault;
   logic [CW-1:0] position;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int            m_rcnt;
   int            m_mode;
   int            m_sector;
   int            m_dt;
   logic          m_fault;
   logic [CW-1:0] m_pos;
   logic [5:0]    m_gate;
   logic          m_dirp;
   logic [2:0]    m_hq [2];
   logic [2:0]    m_prev;
   int            m_run;
   logic          m_seen;
   logic [2:0]    m_acc;
   logic          m_ev_stb;
   logic [2:0]    m_ev_code;

   // dead-time gap measurement
   logic zr_on = 1'b0;
   int   zr = 0;
   int   runs = 0;

   logic [2:0] vcodes [6];
   logic [2:0] code;

   bldc_commutator #(
      .DEADTIME_CYCLES(DT),
      .DEBOUNCE_CYCLES(DEB),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .dir       (dir),
      .pwm_in    (pwm_in),
      .hall      (hall),
      .fault_clr (fault_clr),
      .gate      (gate),
      .sector    (sector),
      .fault     (fault),
      .position  (position)
   );

   always #5 clk = ~clk;

   function automatic int dec(input logic [2:0] c);
      case (c)
         3'b101:  return 0;
         3'b100:  return 1;
         3'b110:  return 2;
         3'b010:  return 3;
         3'b011:  return 4;
         3'b001:  return 5;
         default: return 7;
      endcase
   endfunction

   // phase index 0=A, 1=B, 2=C
   function automatic int hi_phase(input int s);
      case (s)
         0, 1:    return 0;
         2, 3:    return 1;
         default: return 2;
      endcase
   endfunction

   function automatic int lo_phase(input int s);
      case (s)
         0:       return 1;
         1, 2:    return 2;
         3, 4:    return 0;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_rcnt    = 0;
      m_mode    = M_IDLE;
      m_sector  = 7;
      m_dt      = 0;
      m_fault   = 1'b0;
      m_pos     = '0;
      m_gate    = 6'b000000;
      m_dirp    = 1'b0;
      m_hq[0]   = 3'd0;
      m_hq[1]   = 3'd0;
      m_prev    = 3'd0;
      m_run     = 0;
      m_seen    = 1'b0;
      m_acc     = 3'd0;
      m_ev_stb  = 1'b0;
      m_ev_code = 3'd0;
   endtask

   task automatic model_step();
      int         ds;
      int         ns;
      int         nm;
      int         hi;
      int         lo;
      int         t;
      logic       bad;
      logic       chg;
      logic [2:0] consumed;
      ds  = dec(m_ev_code);
      bad = m_ev_stb && (ds == 7);
      ns  = (m_ev_stb && (ds != 7)) ? ds : m_sector;
      chg = (ns != m_sector);
      if (chg && (m_sector != 7)) begin
         if (ns == (m_sector + 1) % 6)      m_pos = m_pos + 24'd1;
         else if (ns == (m_sector + 5) % 6) m_pos = m_pos - 24'd1;
      end
      nm = m_mode;
      case (m_mode)
         M_IDLE:
            if (enable && (m_sector != 7)) begin nm = M_DEAD; m_dt = DT; end
         M_DEAD:
            if (!enable) nm = M_IDLE;
            else begin
               m_dt--;
               if (m_dt == 0) nm = M_DRIVE;
            end
         M_DRIVE:
            if (!enable) nm = M_IDLE;
            else if (chg || (dir != m_dirp)) begin nm = M_DEAD; m_dt = DT; end
         default:
            if (fault_clr && (dec(m_acc) != 7)) begin nm = M_IDLE; m_fault = 1'b0; end
      endcase
      if (bad) begin nm = M_FAULT; m_fault = 1'b1; end
      m_gate = 6'b000000;
      if (nm == M_DRIVE) begin
         hi = hi_phase(ns);
         lo = lo_phase(ns);
         if (dir) begin t = hi; hi = lo; lo = t; end
         if (pwm_in) m_gate = m_gate | (6'b100000 >> (2 * hi));
         m_gate = m_gate | (6'b010000 >> (2 * lo));
      end
      m_sector = ns;
      m_mode   = nm;
      m_dirp   = dir;
      // hall filter: value two samples old, accepted after DEB equal samples
      consumed = m_hq[0];
      m_hq[0]  = m_hq[1];
      m_hq[1]  = hall;
      if (consumed == m_prev) m_run++;
      else                    m_run = 1;
      m_prev    = consumed;
      m_ev_stb  = (m_run == DEB) && (!m_seen || (consumed != m_acc));
      m_ev_code = consumed;
      if (m_ev_stb) begin
         m_acc  = consumed;
         m_seen = 1'b1;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!reset_n)       model_reset();
      else if (m_rcnt < 2) m_rcnt++;
      else                model_step();
      @(negedge clk);
      chk("gate", 32'(gate), 32'(m_gate));
      chk("sector", 32'(sector), m_sector);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("position", 32'(position), 32'(m_pos));
      chk("overlap", 32'((gate[5] & gate[4]) | (gate[3] & gate[2]) | (gate[1] & gate[0])), 32'd0);
      if (zr_on) begin
         if (gate == 6'b000000) zr++;
         else begin
            if (zr > 0) begin
               runs++;
               chk("deadtime_len", zr, DT);
            end
            zr = 0;
         end
      end
   endtask

   initial begin
      vcodes[0] = 3'b101; vcodes[1] = 3'b100; vcodes[2] = 3'b110;
      vcodes[3] = 3'b010; vcodes[4] = 3'b011; vcodes[5] = 3'b001;
      reset_n = 1'b0; enable = 1'b0; dir = 1'b0; pwm_in = 1'b0;
      hall = 3'b101; fault_clr = 1'b0;
      model_reset();
      repeat (3) cyc();
      chk("rst_gate", 32'(gate), 32'd0);
      chk("rst_sector", 32'(sector), 32'd7);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_position", 32'(position), 32'd0);

      // first drive, forward sector 0
      reset_n = 1'b1; enable = 1'b1; pwm_in = 1'b1;
      repeat (70) cyc();
      chk("first_gate", 32'(gate), 32'b100100);
      chk("first_sector", 32'(sector), 32'd0);
      pwm_in = 1'b0;
      chk("pwm_latency_hold", 32'(gate), 32'b100100);
      cyc();
      chk("pwm_latency_low", 32'(gate), 32'b000100);

      // forward rotation
      zr_on = 1'b1; zr = 0; runs = 0;
      for (int i = 1; i <= 6; i++) begin
         hall = vcodes[i % 6];
         repeat (500) begin pwm_in = 1'($urandom_range(0, 1)); cyc(); end
      end
      zr_on = 1'b0;
      chk("fwd_runs", runs, 6);
      chk("fwd_position", 32'(position), 32'd6);
      chk("fwd_sector", 32'(sector), 32'd0);

      // reverse rotation from a fresh reset
      reset_n = 1'b0;
      repeat (2) cyc();
      dir = 1'b1; pwm_in = 1'b1; hall = 3'b101;
      reset_n = 1'b1;
      repeat (70) cyc();
      chk("rev_gate", 32'(gate), 32'b011000);
      for (int i = 5; i >= 0; i--) begin
         hall = vcodes[i];
         repeat (500) begin pwm_in = 1'($urandom_range(0, 1)); cyc(); end
      end
      chk("rev_position", 32'(position), 32'h00FFFFFA);
      chk("rev_sector", 32'(sector), 32'd0);

      // short glitch must be filtered out
      pwm_in = 1'b1; zr_on = 1'b1; zr = 0; runs = 0;
      hall = 3'b100;
      repeat (10) cyc();
      hall = 3'b101;
      repeat (100) cyc();
      zr_on = 1'b0;
      chk("glitch_runs", runs + zr, 0);
      chk("glitch_position", 32'(position), 32'h00FFFFFA);
      chk("glitch_sector", 32'(sector), 32'd0);

      // invalid hall fault and recovery
      hall = 3'b111;
      repeat (45) cyc();
      chk("fault_set", 32'(fault), 32'd1);
      chk("fault_gate", 32'(gate), 32'd0);
      chk("fault_sector", 32'(sector), 32'd0);
      fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
      repeat (3) cyc();
      chk("fault_clr_ignored", 32'(fault), 32'd1);
      hall = 3'b101;
      repeat (45) cyc();
      chk("fault_still", 32'(fault), 32'd1);
      fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
      cyc();
      chk("fault_cleared", 32'(fault), 32'd0);
      repeat (25) cyc();
      chk("resume_gate", 32'(gate), 32'b011000);

      // dir toggle mid-drive, then reset pulse mid-deadtime
      dir = 1'b0; zr_on = 1'b1; zr = 0; runs = 0;
      repeat (30) cyc();
      zr_on = 1'b0;
      chk("dir_runs", runs, 1);
      chk("dir_gate", 32'(gate), 32'b100100);
      dir = 1'b1;
      repeat (6) cyc();
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_gate", 32'(gate), 32'd0);
      chk("async_position", 32'(position), 32'd0);
      chk("async_sector", 32'(sector), 32'd7);
      repeat (2) cyc();
      reset_n = 1'b1;
      repeat (70) cyc();
      chk("post_reset_gate", 32'(gate), 32'b011000);

      // randomised hall, dir, enable, pwm and fault_clr
      repeat (90) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3)      code = 3'b000;
         else if (r < 6) code = 3'b111;
         else            code = vcodes[$urandom_range(0, 5)];
         if ($urandom_range(0, 9) == 0)  dir = ~dir;
         if ($urandom_range(0, 14) == 0) enable = ~enable;
         hall = code;
         repeat ($urandom_range(1, 80)) begin
            pwm_in    = 1'($urandom_range(0, 1));
            fault_clr = ($urandom_range(0, 29) == 0);
            cyc();
         end
      end
      fault_clr = 1'b0;
      repeat (5) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
